// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer.
// Opcode constants, FSM state encoding and the op-class decode.
package alu_seq_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_OR  = 5'b00010;
    localparam logic [OP_W-1:0] OP_MUL = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT = 5'b10010;

    typedef enum logic [2:0] {
        IDLE,
        S_Y,
        S_ALU,
        S_ZLO,
        S_ZHI,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_BINARY,
        CLS_UNARY,
        CLS_MULTI
    } op_class_e;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        op_class_e c;
        case (op)
            OP_NEG, OP_NOT: c = CLS_UNARY;
            OP_MUL, OP_DIV: c = CLS_MULTI;
            default:        c = CLS_BINARY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index to one-hot strobe decoder with enable.
// All-zero output when disabled.
module onehot_decoder #(
    parameter int IDX_W    = 4,
    parameter int NUM_REGS = 16
) (
    input  logic [IDX_W-1:0]    idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // one bit per register, at most one set
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (idx == i[IDX_W-1:0]);
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshake-driven microsequencer for register-register ALU ops.
// Optional perf counters: define ALU_SEQ_PERF_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int OP_W     = alu_seq_pkg::OP_W,
    parameter int MAX_WAIT = 64
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                start,
    input  logic [OP_W-1:0]     op,
    input  logic [IDX_W-1:0]    ra,
    input  logic [IDX_W-1:0]    rb,
    input  logic [IDX_W-1:0]    rc,
    input  logic                alu_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [OP_W-1:0]     alu_op,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [31:0]         op_count,
    output logic [31:0]         stall_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [IDX_W:0] NREG = (IDX_W + 1)'(NUM_REGS);

    state_e            state;
    logic [OP_W-1:0]   op_q;
    logic [IDX_W-1:0]  ra_q;
    logic [IDX_W-1:0]  rb_q;
    logic [IDX_W-1:0]  rc_q;
    logic [WAIT_W-1:0] wait_q;
    logic              err_q;

    logic              idx_ok;
    logic              is_multi;
    logic              is_unary;
    logic              new_unary;
    logic              out_en;
    logic              in_en;
    logic [IDX_W-1:0]  out_idx;

    assign idx_ok = ({1'b0, ra} < NREG) &&
                    ({1'b0, rb} < NREG) &&
                    ({1'b0, rc} < NREG);

    assign is_multi  = (op_class(op_q) == CLS_MULTI);
    assign is_unary  = (op_class(op_q) == CLS_UNARY);
    assign new_unary = (op_class(op) == CLS_UNARY);

    // sequencing FSM: capture, walk bus phases, time out on alu_ready
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            op_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            rc_q   <= '0;
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (idx_ok) begin
                            op_q   <= op;
                            ra_q   <= ra;
                            rb_q   <= rb;
                            rc_q   <= rc;
                            wait_q <= '0;
                            state  <= new_unary ? S_ALU : S_Y;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_Y: state <= S_ALU;
                S_ALU: begin
                    if (!is_multi || alu_ready) begin
                        state <= S_ZLO;
                    end else if (wait_q == WAIT_LAST) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_ZLO:  state <= is_multi ? S_ZHI : S_DONE;
                S_ZHI:  state <= S_DONE;
                S_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // strobe decode from registered state and captured fields
    always_comb begin
        busy     = (state != IDLE) && (state != S_DONE);
        done     = (state == S_DONE);
        err      = err_q;
        alu_op   = (state == S_ALU) ? op_q : '0;
        out_en   = (state == S_Y) || (state == S_ALU);
        out_idx  = ((state == S_Y) || is_unary) ? rb_q : rc_q;
        in_en    = (state == S_ZLO) && !is_multi;
        Yin      = (state == S_Y);
        Zin      = (state == S_ALU) && (!is_multi || alu_ready);
        Zlowout  = (state == S_ZLO);
        LOin     = (state == S_ZLO) && is_multi;
        Zhighout = (state == S_ZHI);
        HIin     = (state == S_ZHI);
    end

    onehot_decoder #(
        .IDX_W   (IDX_W),
        .NUM_REGS(NUM_REGS)
    ) u_out_dec (
        .idx   (out_idx),
        .en    (out_en),
        .onehot(reg_out)
    );

    onehot_decoder #(
        .IDX_W   (IDX_W),
        .NUM_REGS(NUM_REGS)
    ) u_in_dec (
        .idx   (ra_q),
        .en    (in_en),
        .onehot(reg_in)
    );

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] op_cnt_q;
    logic [31:0] stall_cnt_q;

    // completed-op and alu_ready stall counters, wrapping
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            op_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state == S_DONE) begin
                op_cnt_q <= op_cnt_q + 32'd1;
            end
            if ((state == S_ALU) && is_multi && !alu_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign op_count    = op_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign op_count    = '0;
    assign stall_count = '0;
`endif

endmodule
